// File: rtl/cga_mem_pkg.sv
// Shared types and widths for the memory-cycle sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cga_mem_pkg;

  // Sequencer states: idle, bus request outstanding, completion cycle,
  // and recovery while waiting for the acknowledge to fall.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    RECOV = 2'd3
  } state_e;

  localparam int TMO_W = 8;   // timeout counter width
  localparam int PA_W  = 24;  // physical address width

endpackage

// File: rtl/cga_mac_memcyc_tmo.sv
// Bus-request timeout counter with synchronous clear, enable and terminal count.
// Latency: count updates on the edge after clr_i/en_i; tc_o is combinational from the count.
// Backpressure: none; counts whenever en_i is high.
//
// Ports:
//   MCLK    clock
//   PONI_N  synchronous active-low reset
//   clr_i   clear count to 0 (has priority over en_i)
//   en_i    increment count
//   tc_o    count == TMO_CYCLES-1
module cga_mac_memcyc_tmo
  import cga_mem_pkg::*;
#(
  parameter int TMO_CYCLES = 255
) (
  input  logic MCLK,
  input  logic PONI_N,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [TMO_W-1:0] TC_VAL = TMO_W'(TMO_CYCLES - 1);

  logic [TMO_W-1:0] count_q;
  logic [TMO_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + {{(TMO_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge MCLK) begin
    if (!PONI_N) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/cga_mac_memcyc.sv
// Memory-cycle sequencer: runs one four-phase MREQ/MACK bus cycle per accepted CPU request.
// Latency: request accepted at edge 0 -> MREQ in cycle 1; MACK at edge k -> MDONE/RDATA in cycle k+1.
// Backpressure: none; requests arriving while BUSY are dropped and flagged with a one-cycle ORUN.
//
// Ports:
//   MCLK, PONI_N              clock, synchronous active-low reset
//   CSMREQ, CSWRITE, VEX      request, direction, MAC violation (qualified by CSMREQ)
//   LA_23_10, MCA_9_0         translated address from the MAC
//   CD_15_0                   write data
//   MDI_15_0, MACK            memory read data and acknowledge
//   PA_23_0, MDO_15_0, MWRITE latched address, write data, direction
//   MREQ, BUSY                bus request, sequencer not idle
//   RDATA_15_0                captured read data
//   MDONE, MPV, MTO, ORUN     one-cycle outcome pulses
module cga_mac_memcyc
  import cga_mem_pkg::*;
#(
  parameter int TMO_CYCLES = 255
) (
  input  logic            MCLK,
  input  logic            PONI_N,
  input  logic            CSMREQ,
  input  logic            CSWRITE,
  input  logic [13:0]     LA_23_10,
  input  logic [9:0]      MCA_9_0,
  input  logic            VEX,
  input  logic [15:0]     CD_15_0,
  input  logic [15:0]     MDI_15_0,
  input  logic            MACK,
  output logic [PA_W-1:0] PA_23_0,
  output logic [15:0]     MDO_15_0,
  output logic            MWRITE,
  output logic            MREQ,
  output logic [15:0]     RDATA_15_0,
  output logic            BUSY,
  output logic            MDONE,
  output logic            MPV,
  output logic            MTO,
  output logic            ORUN
);

  state_e            state_q, state_d;
  logic [PA_W-1:0]   pa_q, pa_d;
  logic [15:0]       mdo_q, mdo_d;
  logic              mwrite_q, mwrite_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              mpv_q, mpv_d;
  logic              mto_q, mto_d;
  logic              orun_q, orun_d;

  logic              tmo_clr;
  logic              tmo_en;
  logic              tmo_tc;

  cga_mac_memcyc_tmo #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_tmo (
    .MCLK   (MCLK),
    .PONI_N (PONI_N),
    .clr_i  (tmo_clr),
    .en_i   (tmo_en),
    .tc_o   (tmo_tc)
  );

  always_comb begin
    state_d  = state_q;
    pa_d     = pa_q;
    mdo_d    = mdo_q;
    mwrite_d = mwrite_q;
    rdata_d  = rdata_q;
    mpv_d    = 1'b0;
    mto_d    = 1'b0;
    tmo_clr  = 1'b0;
    tmo_en   = 1'b0;

    // Any request seen while a cycle is in flight is dropped, including the
    // one on the edge that closes the DONE cycle.
    orun_d   = CSMREQ && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (CSMREQ) begin
          if (VEX) begin
            mpv_d = 1'b1;
          end else begin
            pa_d     = {LA_23_10, MCA_9_0};
            mdo_d    = CD_15_0;
            mwrite_d = CSWRITE;
            tmo_clr  = 1'b1;
            state_d  = REQ;
          end
        end
      end

      REQ: begin
        // Acknowledge takes priority over a simultaneous terminal count.
        if (MACK) begin
          if (!mwrite_q) begin
            rdata_d = MDI_15_0;
          end
          state_d = DONE;
        end else if (tmo_tc) begin
          mto_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_en = 1'b1;
        end
      end

      DONE: begin
        state_d = MACK ? RECOV : IDLE;
      end

      RECOV: begin
        if (!MACK) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (!PONI_N) begin
      state_q  <= IDLE;
      pa_q     <= '0;
      mdo_q    <= '0;
      mwrite_q <= 1'b0;
      rdata_q  <= '0;
      mpv_q    <= 1'b0;
      mto_q    <= 1'b0;
      orun_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pa_q     <= pa_d;
      mdo_q    <= mdo_d;
      mwrite_q <= mwrite_d;
      rdata_q  <= rdata_d;
      mpv_q    <= mpv_d;
      mto_q    <= mto_d;
      orun_q   <= orun_d;
    end
  end

  // Bus-side and status outputs decode straight from the state register.
  assign MREQ       = (state_q == REQ);
  assign BUSY       = (state_q != IDLE);
  assign MDONE      = (state_q == DONE);
  assign PA_23_0    = pa_q;
  assign MDO_15_0   = mdo_q;
  assign MWRITE     = mwrite_q;
  assign RDATA_15_0 = rdata_q;
  assign MPV        = mpv_q;
  assign MTO        = mto_q;
  assign ORUN       = orun_q;

endmodule

// File: tb/tb_cga_mac_memcyc.sv
// Self-checking bench for cga_mac_memcyc: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
// The model is evaluated every edge and compared on every falling edge.
module tb_cga_mac_memcyc;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        poni_n = 1'b0;
  logic        csmreq = 1'b0;
  logic        cswrite = 1'b0;
  logic [13:0] la = '0;
  logic [9:0]  mca = '0;
  logic        vex = 1'b0;
  logic [15:0] cd = '0;
  logic [15:0] mdi = '0;
  logic        mack = 1'b0;

  logic [23:0] pa;
  logic [15:0] mdo;
  logic        mwrite;
  logic        mreq;
  logic [15:0] rdata;
  logic        busy;
  logic        mdone;
  logic        mpv;
  logic        mto;
  logic        orun;

  cga_mac_memcyc #(.TMO_CYCLES(TMO)) dut (
    .MCLK       (clk),
    .PONI_N     (poni_n),
    .CSMREQ     (csmreq),
    .CSWRITE    (cswrite),
    .LA_23_10   (la),
    .MCA_9_0    (mca),
    .VEX        (vex),
    .CD_15_0    (cd),
    .MDI_15_0   (mdi),
    .MACK       (mack),
    .PA_23_0    (pa),
    .MDO_15_0   (mdo),
    .MWRITE     (mwrite),
    .MREQ       (mreq),
    .RDATA_15_0 (rdata),
    .BUSY       (busy),
    .MDONE      (mdone),
    .MPV        (mpv),
    .MTO        (mto),
    .ORUN       (orun)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks "a bus cycle is in flight", how many cycles MREQ has been high,
  // and the latched values; pulses are recomputed fresh every edge.
  bit          m_busy = 0, m_mreq = 0, m_done = 0, m_mpv = 0, m_mto = 0, m_orun = 0;
  bit          m_mwrite = 0;
  logic [23:0] m_pa = '0;
  logic [15:0] m_mdo = '0, m_rdata = '0;
  int          m_reqlen = 0;

  always @(posedge clk) begin
    bit n_busy, n_mreq, n_done, n_mpv, n_mto, n_orun;
    if (!poni_n) begin
      m_busy = 0; m_mreq = 0; m_done = 0; m_mpv = 0; m_mto = 0; m_orun = 0;
      m_mwrite = 0; m_pa = '0; m_mdo = '0; m_rdata = '0; m_reqlen = 0;
    end else begin
      n_busy = m_busy; n_mreq = m_mreq;
      n_done = 0; n_mpv = 0; n_mto = 0;
      n_orun = csmreq && m_busy;
      if (!m_busy) begin
        if (csmreq) begin
          if (vex) begin
            n_mpv = 1;
          end else begin
            n_busy = 1; n_mreq = 1; m_reqlen = 1;
            m_pa = {la, mca}; m_mdo = cd; m_mwrite = cswrite;
          end
        end
      end else if (m_mreq) begin
        if (mack) begin
          n_mreq = 0; n_done = 1;
          if (!m_mwrite) m_rdata = mdi;
        end else if (m_reqlen == TMO) begin
          n_mreq = 0; n_busy = 0; n_mto = 1;
        end else begin
          m_reqlen++;
        end
      end else begin
        // after the acknowledge: busy until MACK is seen low
        if (!mack) n_busy = 0;
      end
      m_busy = n_busy; m_mreq = n_mreq; m_done = n_done;
      m_mpv = n_mpv; m_mto = n_mto; m_orun = n_orun;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_busy",   busy,   m_busy);
      chk("m_mreq",   mreq,   m_mreq);
      chk("m_mdone",  mdone,  m_done);
      chk("m_mpv",    mpv,    m_mpv);
      chk("m_mto",    mto,    m_mto);
      chk("m_orun",   orun,   m_orun);
      chk("m_mwrite", mwrite, m_mwrite);
      chk("m_pa",     pa,     m_pa);
      chk("m_mdo",    mdo,    m_mdo);
      chk("m_rdata",  rdata,  m_rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit wr, input logic [13:0] a_hi, input logic [9:0] a_lo,
                     input logic [15:0] d);
    csmreq = 1'b1; cswrite = wr; la = a_hi; mca = a_lo; cd = d; vex = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    poni_n = 1'b0;
    step(); step();
    cmp_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_mreq", mreq, 0);
    chk("rst_pa", pa, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_pulses", {mdone, mpv, mto, orun}, 0);
    poni_n = 1'b1;
    step();

    // read, ack in 3rd REQ cycle, MACK held through two more cycles
    req(0, 14'h0ABC, 10'h155, 16'h0000);
    step(); csmreq = 1'b0;
    chk("rd_pa", pa, 24'h2AF155);
    chk("rd_mreq1", {mreq, busy}, 2'b11);
    step(); chk("rd_mreq2", mreq, 1);
    step(); chk("rd_mreq3", mreq, 1);
    mack = 1'b1; mdi = 16'hBEEF;
    step();
    chk("rd_done", {mreq, mdone}, 2'b01);
    chk("rd_rdata", rdata, 16'hBEEF);
    mdi = 16'h0000;
    step(); chk("rd_recov", {busy, mreq, mdone}, 3'b100);
    step(); mack = 1'b0;
    step(); chk("rd_idle", busy, 0);

    // write
    req(1, 14'h1111, 10'h022, 16'h1234);
    step(); csmreq = 1'b0;
    chk("wr_mdo", mdo, 16'h1234);
    chk("wr_mwrite", {mwrite, mreq}, 2'b11);
    mack = 1'b1; mdi = 16'h5555;
    step(); chk("wr_done", mdone, 1);
    chk("wr_rdata_kept", rdata, 16'hBEEF);
    mack = 1'b0;
    step(); chk("wr_idle", busy, 0);

    // violation
    req(0, 14'h3FFF, 10'h3FF, 16'h0); vex = 1'b1;
    step(); csmreq = 1'b0; vex = 1'b0;
    chk("pv_mpv", {mpv, mreq, busy}, 3'b100);
    chk("pv_pa", pa, {14'h1111, 10'h022});
    step(); chk("pv_clr", {mpv, mreq}, 2'b00);

    // timeout: MREQ high exactly TMO cycles
    req(0, 14'h0001, 10'h001, 16'h0);
    step(); csmreq = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      chk("to_mreq", mreq, 1);
      if (i < TMO - 1) step();
    end
    step(); chk("to_mto", {mto, mreq, busy}, 3'b100);
    step(); chk("to_mto_clr", mto, 0);

    // ack on last REQ cycle wins over timeout
    req(0, 14'h0002, 10'h002, 16'h0);
    step(); csmreq = 1'b0;
    step(); step(); step();
    mack = 1'b1; mdi = 16'hA5A5;
    step(); chk("tw_done_no_mto", {mdone, mto}, 2'b10);
    chk("tw_rdata", rdata, 16'hA5A5);
    mack = 1'b0;
    step(); chk("tw_idle", busy, 0);

    // overrun during REQ
    req(0, 14'h0003, 10'h003, 16'h0);
    step(); la = 14'h2222;
    step(); csmreq = 1'b0;
    chk("or_orun", orun, 1);
    chk("or_pa", pa, {14'h0003, 10'h003});
    mack = 1'b1;
    step(); chk("or_done", mdone, 1);
    mack = 1'b0;
    step(); chk("or_idle", busy, 0);

    // back-to-back: request at the edge closing DONE is dropped
    req(1, 14'h0004, 10'h004, 16'h4444);
    step(); csmreq = 1'b0; mack = 1'b1;
    step(); mack = 1'b0; req(1, 14'h0005, 10'h005, 16'h5555);
    step(); csmreq = 1'b0;
    chk("bb_orun", {orun, busy, mreq}, 3'b100);
    step();

    // reset during REQ
    req(0, 14'h0006, 10'h006, 16'h0);
    step(); csmreq = 1'b0;
    chk("rr_mreq", mreq, 1);
    poni_n = 1'b0;
    step();
    chk("rr_out", {mreq, busy, mdone, mto}, 4'b0000);
    chk("rr_pa", pa, 0);
    poni_n = 1'b1;
    step();

    // randomized traffic with a loose four-phase responder
    for (int c = 0; c < 3000; c++) begin
      step();
      poni_n  = ($urandom_range(0, 199) != 0);
      csmreq  = ($urandom_range(0, 2) == 0);
      cswrite = $urandom_range(0, 1) == 1;
      vex     = ($urandom_range(0, 4) == 0);
      la      = 14'($urandom);
      mca     = 10'($urandom);
      cd      = 16'($urandom);
      mdi     = 16'($urandom);
      if (mack) mack = ($urandom_range(0, 1) == 0);
      else if (mreq) mack = ($urandom_range(0, 2) == 0);
      else mack = 1'b0;
    end
    csmreq = 1'b0; mack = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
